// File: rtl/sme_ff_scheduler_pkg.sv
// Shared definitions for the failure-function scheduler: parameter defaults, FSM states,
// and an index-width helper.
package sme_ff_scheduler_pkg;

  localparam int unsigned SmeNumReq     = 4;
  localparam int unsigned SmeMaxPattern = 8;
  localparam int unsigned SmeMaxPatAdd  = 3;
  localparam int unsigned SmeByte       = 8;
  localparam int unsigned SmeTimeout    = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } sched_state_e;

  // Bits needed to hold a slot index; never zero so single-slot builds stay legal.
  function automatic int unsigned sme_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sme_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_rr_ptr,
// wrapping modulo NUM_REQ.
module sme_rr_arbiter
  import sme_ff_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = SmeNumReq,
  localparam int unsigned IdxW   = sme_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IdxW-1:0]    o_idx,
  output logic               o_valid
);

  logic [IdxW-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_cand = IdxW'((32'(i_rr_ptr) + off) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/sme_ff_scheduler.sv
// Shares one failure-function engine among NUM_REQ requesters: round-robin grant,
// per-slot result tables, watchdog on the engine, drain until the engine releases done.
module sme_ff_scheduler
  import sme_ff_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = SmeNumReq,
  parameter int unsigned MAX_PATTERN = SmeMaxPattern,
  parameter int unsigned MAX_PAT_ADD = SmeMaxPatAdd,
  parameter int unsigned BYTE        = SmeByte,
  parameter int unsigned TIMEOUT     = SmeTimeout
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ*MAX_PATTERN*BYTE-1:0]    i_req_pattern,
  input  logic [NUM_REQ*MAX_PAT_ADD-1:0]         i_req_last_idx,
  output logic [NUM_REQ-1:0]                     o_gnt,
  output logic [NUM_REQ-1:0]                     o_done,
  output logic [NUM_REQ-1:0]                     o_err,
  output logic [NUM_REQ*MAX_PATTERN*MAX_PAT_ADD-1:0] o_ff_table,
  output logic [NUM_REQ-1:0]                     o_ff_valid,
  output logic                                   o_busy,
  output logic                                   o_eng_valid,
  output logic [MAX_PATTERN*BYTE-1:0]            o_eng_pattern,
  output logic [MAX_PAT_ADD-1:0]                 o_eng_last_idx,
  input  logic [MAX_PATTERN*MAX_PAT_ADD-1:0]     i_eng_fail_func,
  input  logic                                   i_eng_done
);

  localparam int unsigned PatW = MAX_PATTERN * BYTE;
  localparam int unsigned TblW = MAX_PATTERN * MAX_PAT_ADD;
  localparam int unsigned IdxW = sme_idx_w(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  sched_state_e                   r_state, w_state_nxt;
  logic [NUM_REQ-1:0]             r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]             r_done, w_done_nxt;
  logic [NUM_REQ-1:0]             r_err, w_err_nxt;
  logic [NUM_REQ*TblW-1:0]        r_ff_table, w_ff_table_nxt;
  logic [NUM_REQ-1:0]             r_ff_valid, w_ff_valid_nxt;
  logic                           r_busy;
  logic                           r_eng_valid, w_eng_valid_nxt;
  logic [PatW-1:0]                r_eng_pattern, w_eng_pattern_nxt;
  logic [MAX_PAT_ADD-1:0]         r_eng_last_idx, w_eng_last_idx_nxt;
  logic [IdxW-1:0]                r_rr_ptr, w_rr_ptr_nxt;
  logic [IdxW-1:0]                r_slot, w_slot_nxt;
  logic [WdW-1:0]                 r_wd, w_wd_nxt;

  logic [NUM_REQ-1:0]             w_arb_gnt;
  logic [IdxW-1:0]                w_arb_idx;
  logic                           w_arb_valid;

  sme_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_gnt          <= '0;
      r_done         <= '0;
      r_err          <= '0;
      r_ff_table     <= '0;
      r_ff_valid     <= '0;
      r_busy         <= 1'b0;
      r_eng_valid    <= 1'b0;
      r_eng_pattern  <= '0;
      r_eng_last_idx <= '0;
      r_rr_ptr       <= '0;
      r_slot         <= '0;
      r_wd           <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_gnt          <= w_gnt_nxt;
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
      r_ff_table     <= w_ff_table_nxt;
      r_ff_valid     <= w_ff_valid_nxt;
      r_busy         <= (w_state_nxt != StIdle);
      r_eng_valid    <= w_eng_valid_nxt;
      r_eng_pattern  <= w_eng_pattern_nxt;
      r_eng_last_idx <= w_eng_last_idx_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_slot         <= w_slot_nxt;
      r_wd           <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_gnt_nxt          = r_gnt;
    w_done_nxt         = '0;
    w_err_nxt          = '0;
    w_ff_table_nxt     = r_ff_table;
    w_ff_valid_nxt     = r_ff_valid;
    w_eng_valid_nxt    = r_eng_valid;
    w_eng_pattern_nxt  = r_eng_pattern;
    w_eng_last_idx_nxt = r_eng_last_idx;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_slot_nxt         = r_slot;
    w_wd_nxt           = r_wd;

    unique case (r_state)
      StIdle: begin
        if (w_arb_valid) begin
          w_state_nxt               = StRun;
          w_gnt_nxt                 = w_arb_gnt;
          w_slot_nxt                = w_arb_idx;
          w_eng_valid_nxt           = 1'b1;
          w_eng_pattern_nxt         = i_req_pattern[w_arb_idx*PatW +: PatW];
          w_eng_last_idx_nxt        = i_req_last_idx[w_arb_idx*MAX_PAT_ADD +: MAX_PAT_ADD];
          w_ff_valid_nxt[w_arb_idx] = 1'b0;
          w_wd_nxt                  = '0;
          w_rr_ptr_nxt = (w_arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : w_arb_idx + IdxW'(1);
        end
      end
      StRun: begin
        w_wd_nxt = r_wd + WdW'(1);
        // A result arriving on the watchdog's last cycle still counts as success.
        if (i_eng_done) begin
          w_ff_table_nxt[r_slot*TblW +: TblW] = i_eng_fail_func;
          w_ff_valid_nxt[r_slot]              = 1'b1;
          w_done_nxt                          = r_gnt;
          w_eng_valid_nxt                     = 1'b0;
          w_gnt_nxt                           = '0;
          w_state_nxt                         = StDrain;
        end else if (r_wd == WdW'(TIMEOUT - 1)) begin
          w_err_nxt       = r_gnt;
          w_eng_valid_nxt = 1'b0;
          w_gnt_nxt       = '0;
          w_state_nxt     = StDrain;
        end
      end
      StDrain: begin
        w_eng_valid_nxt = 1'b0;
        if (!i_eng_done) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt     = StIdle;
        w_gnt_nxt       = '0;
        w_eng_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_gnt          = r_gnt;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_ff_table     = r_ff_table;
  assign o_ff_valid     = r_ff_valid;
  assign o_busy         = r_busy;
  assign o_eng_valid    = r_eng_valid;
  assign o_eng_pattern  = r_eng_pattern;
  assign o_eng_last_idx = r_eng_last_idx;

endmodule

// File: tb/tb_sme_ff_scheduler.sv
// Self-checking bench: behavioural engine computing KMP failure functions, plus a
// slot-level model of grants, tables and valid bits.
module tb_sme_ff_scheduler;

  localparam int unsigned NR   = 4;
  localparam int unsigned MP   = 8;
  localparam int unsigned MPA  = 3;
  localparam int unsigned BY   = 8;
  localparam int unsigned TO   = 64;
  localparam int unsigned PatW = MP * BY;
  localparam int unsigned TblW = MP * MPA;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NR-1:0]        req = '0;
  logic [NR*PatW-1:0]   req_pat = '0;
  logic [NR*MPA-1:0]    req_last = '0;
  logic [NR-1:0]        o_gnt, o_done, o_err, o_ff_valid;
  logic [NR*TblW-1:0]   o_ff_table;
  logic                 o_busy, o_eng_valid;
  logic [PatW-1:0]      o_eng_pattern;
  logic [MPA-1:0]       o_eng_last_idx;
  logic [TblW-1:0]      eng_ff = '0;
  logic                 eng_done = 1'b0;

  int  eng_lat = 1, eng_hold = 0, e_cnt = 0, e_hold = 0;
  bit  eng_never = 1'b0;
  int  n_tests = 0, n_fail = 0, cyc = 0;

  logic [TblW-1:0] m_tbl [NR];
  logic [NR-1:0]   m_valid;
  int              m_rr;

  sme_ff_scheduler #(
    .NUM_REQ(NR), .MAX_PATTERN(MP), .MAX_PAT_ADD(MPA), .BYTE(BY), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .i_req(req), .i_req_pattern(req_pat),
    .i_req_last_idx(req_last), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
    .o_ff_table(o_ff_table), .o_ff_valid(o_ff_valid), .o_busy(o_busy),
    .o_eng_valid(o_eng_valid), .o_eng_pattern(o_eng_pattern),
    .o_eng_last_idx(o_eng_last_idx), .i_eng_fail_func(eng_ff), .i_eng_done(eng_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [TblW-1:0] kmp(input logic [PatW-1:0] p, input logic [MPA-1:0] last);
    int f[MP];
    int k;
    logic [TblW-1:0] r;
    r = '0;
    k = 0;
    for (int i = 0; i < MP; i++) f[i] = 0;
    for (int i = 1; i <= int'(last); i++) begin
      while (k > 0 && p[i*BY +: BY] != p[k*BY +: BY]) k = f[k-1];
      if (p[i*BY +: BY] == p[k*BY +: BY]) k++;
      f[i] = k;
    end
    for (int i = 0; i <= int'(last); i++) r[i*MPA +: MPA] = MPA'(f[i]);
    return r;
  endfunction

  function automatic logic [NR*TblW-1:0] m_pack();
    logic [NR*TblW-1:0] r;
    for (int s = 0; s < NR; s++) r[s*TblW +: TblW] = m_tbl[s];
    return r;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int o = 0; o < NR; o++) if (r[(p + o) % NR]) return (p + o) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int s);
    logic [NR-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Engine: done after eng_lat valid cycles, held eng_hold cycles past valid drop.
  always @(negedge clk) begin
    if (o_eng_valid === 1'b1) begin
      e_cnt  = e_cnt + 1;
      e_hold = 0;
      if (!eng_never && e_cnt >= eng_lat) begin
        eng_done = 1'b1;
        eng_ff   = kmp(o_eng_pattern, o_eng_last_idx);
      end
    end else begin
      e_cnt = 0;
      if (eng_done) begin
        if (e_hold >= eng_hold) eng_done = 1'b0;
        else e_hold = e_hold + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (o_gnt != '0) begin k = i; break; end
    end
  endtask

  task automatic wait_resp(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((o_done | o_err) != '0) begin k = i; break; end
    end
  endtask

  task automatic model_clear();
    m_valid = '0;
    m_rr = 0;
    for (int s = 0; s < NR; s++) m_tbl[s] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic rand_patterns();
    for (int s = 0; s < NR; s++) begin
      for (int b = 0; b < MP; b++) req_pat[(s*MP + b)*BY +: BY] = BY'($urandom_range(65, 67));
      req_last[s*MPA +: MPA] = MPA'($urandom_range(1, MP - 1));
    end
  endtask

  task automatic test_reset();
    rand_patterns();
    do_reset();
    n_tests++; if (o_gnt !== '0) begin n_fail++; $display("FAIL rst_gnt got %b want 0", o_gnt); end
    n_tests++; if (o_done !== '0 || o_err !== '0) begin n_fail++;
      $display("FAIL rst_done_err got %b/%b want 0/0", o_done, o_err); end
    n_tests++; if (o_ff_valid !== '0) begin n_fail++; $display("FAIL rst_ffv got %b want 0", o_ff_valid); end
    n_tests++; if (o_ff_table !== '0) begin n_fail++; $display("FAIL rst_tbl got %h want 0", o_ff_table); end
    n_tests++; if (o_busy !== 1'b0 || o_eng_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_busy_valid got %b/%b want 0/0", o_busy, o_eng_valid); end
    n_tests++; if (o_eng_pattern !== '0 || o_eng_last_idx !== '0) begin n_fail++;
      $display("FAIL rst_eng_bus got %h/%h want 0/0", o_eng_pattern, o_eng_last_idx); end
  endtask

  task automatic test_single();
    string s;
    int exp_ff[8];
    logic [TblW-1:0] ev;
    int k;
    s = "ABABCABA";
    exp_ff = '{0, 0, 1, 2, 0, 1, 2, 3};
    do_reset();
    rand_patterns();
    for (int i = 0; i < MP; i++) req_pat[(2*MP + i)*BY +: BY] = s[i];
    req_last[2*MPA +: MPA] = 3'd7;
    for (int i = 0; i < MP; i++) ev[i*MPA +: MPA] = MPA'(exp_ff[i]);
    eng_lat = 10; eng_hold = 0; eng_never = 1'b0;
    req = 4'b0100;
    tick();
    n_tests++; if (o_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", o_gnt); end
    n_tests++; if (o_eng_valid !== 1'b1 || o_busy !== 1'b1) begin n_fail++;
      $display("FAIL single_valid got %b/%b want 1/1", o_eng_valid, o_busy); end
    n_tests++; if (o_eng_pattern !== req_pat[2*PatW +: PatW] || o_eng_last_idx !== 3'd7) begin
      n_fail++; $display("FAIL single_latch got %h/%0d want %h/7", o_eng_pattern, o_eng_last_idx,
                         req_pat[2*PatW +: PatW]); end
    wait_resp(40, k);
    n_tests++; if (k !== 10) begin n_fail++; $display("FAIL single_latency got %0d want 10", k); end
    n_tests++; if (o_done !== 4'b0100 || o_err !== '0) begin n_fail++;
      $display("FAIL single_done got %b/%b want 0100/0000", o_done, o_err); end
    m_tbl[2] = ev; m_valid[2] = 1'b1;
    n_tests++; if (o_ff_table !== m_pack()) begin n_fail++;
      $display("FAIL single_table got %h want %h", o_ff_table, m_pack()); end
    n_tests++; if (o_ff_valid !== 4'b0100 || o_gnt !== '0 || o_busy !== 1'b1) begin n_fail++;
      $display("FAIL single_post got ffv %b gnt %b busy %b want 0100 0000 1", o_ff_valid, o_gnt, o_busy); end
    req = '0;
    tick();
    n_tests++; if (o_done !== '0 || o_busy !== 1'b0) begin n_fail++;
      $display("FAIL single_pulse got done %b busy %b want 0000 0", o_done, o_busy); end
  endtask

  task automatic test_fairness();
    int order[5];
    int k, s;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    rand_patterns();
    eng_hold = 1;
    req = '1;
    for (int g = 0; g < 5; g++) begin
      s = order[g];
      eng_lat = $urandom_range(1, 12);
      wait_gnt(20, k);
      n_tests++; if (o_gnt !== onehot(s)) begin n_fail++;
        $display("FAIL fair_gnt%0d got %b want %b (k=%0d)", g, o_gnt, onehot(s), k); end
      m_valid[s] = 1'b0;
      n_tests++; if (o_ff_valid !== m_valid) begin n_fail++;
        $display("FAIL fair_ffv_clear%0d got %b want %b", g, o_ff_valid, m_valid); end
      wait_resp(40, k);
      n_tests++; if (o_done !== onehot(s) || o_err !== '0) begin n_fail++;
        $display("FAIL fair_done%0d got %b/%b want %b/0000", g, o_done, o_err, onehot(s)); end
      m_tbl[s] = kmp(req_pat[s*PatW +: PatW], req_last[s*MPA +: MPA]);
      m_valid[s] = 1'b1;
      n_tests++; if (o_ff_table !== m_pack() || o_ff_valid !== m_valid) begin n_fail++;
        $display("FAIL fair_table%0d got %h/%b want %h/%b", g, o_ff_table, o_ff_valid, m_pack(), m_valid); end
      req[s] = 1'b0;
      tick();
      req[s] = 1'b1;
    end
    req = '0;
    eng_hold = 0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int k, s, last_cyc;
    do_reset();
    rand_patterns();
    eng_lat = 1; eng_hold = 0;
    req = '1;
    last_cyc = 0;
    for (int j = 0; j < 8; j++) begin
      s = rr_pick(req, m_rr);
      wait_gnt(20, k);
      n_tests++; if (o_gnt !== onehot(s)) begin n_fail++;
        $display("FAIL b2b_gnt%0d got %b want %b", j, o_gnt, onehot(s)); end
      if (j > 0) begin
        n_tests++; if (cyc - last_cyc != 3) begin n_fail++;
          $display("FAIL b2b_spacing%0d got %0d want 3", j, cyc - last_cyc); end
      end
      last_cyc = cyc;
      m_rr = (s + 1) % NR;
      wait_resp(10, k);
      m_tbl[s] = kmp(req_pat[s*PatW +: PatW], req_last[s*MPA +: MPA]);
      n_tests++; if (o_done !== onehot(s) || o_ff_table !== m_pack()) begin n_fail++;
        $display("FAIL b2b_done%0d got %b/%h want %b/%h", j, o_done, o_ff_table, onehot(s), m_pack()); end
      req[s] = 1'b0;
      tick();
      req[s] = 1'b1;
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_watchdog();
    int k;
    bit saw_done;
    do_reset();
    rand_patterns();
    eng_never = 1'b1;
    req = 4'b0010;
    tick();
    n_tests++; if (o_gnt !== 4'b0010) begin n_fail++; $display("FAIL wd_gnt got %b want 0010", o_gnt); end
    k = -1;
    saw_done = 1'b0;
    for (int i = 1; i <= int'(TO) + 8; i++) begin
      tick();
      if (o_done != '0) saw_done = 1'b1;
      if (o_err != '0) begin k = i; break; end
    end
    n_tests++; if (k != int'(TO)) begin n_fail++; $display("FAIL wd_latency got %0d want %0d", k, TO); end
    n_tests++; if (o_err !== 4'b0010 || saw_done) begin n_fail++;
      $display("FAIL wd_err got %b done_seen %0d want 0010 0", o_err, saw_done); end
    n_tests++; if (o_ff_valid !== '0 || o_ff_table !== '0) begin n_fail++;
      $display("FAIL wd_table got %b/%h want 0/0", o_ff_valid, o_ff_table); end
    n_tests++; if (o_gnt !== '0 || o_eng_valid !== 1'b0 || o_busy !== 1'b1) begin n_fail++;
      $display("FAIL wd_drain got gnt %b v %b busy %b want 0000 0 1", o_gnt, o_eng_valid, o_busy); end
    req = '0;
    tick();
    n_tests++; if (o_busy !== 1'b0 || o_err !== '0) begin n_fail++;
      $display("FAIL wd_idle got busy %b err %b want 0 0000", o_busy, o_err); end
    eng_never = 1'b0;
  endtask

  task automatic test_collision();
    int k;
    do_reset();
    rand_patterns();
    eng_lat = TO; eng_hold = 0;
    req = 4'b0001;
    wait_gnt(5, k);
    wait_resp(int'(TO) + 8, k);
    n_tests++; if (k != int'(TO)) begin n_fail++; $display("FAIL coll_latency got %0d want %0d", k, TO); end
    n_tests++; if (o_done !== 4'b0001 || o_err !== '0) begin n_fail++;
      $display("FAIL coll_result got %b/%b want 0001/0000", o_done, o_err); end
    n_tests++; if (o_ff_valid !== 4'b0001) begin n_fail++;
      $display("FAIL coll_ffv got %b want 0001", o_ff_valid); end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_drain_hold();
    int k;
    do_reset();
    rand_patterns();
    eng_lat = 3; eng_hold = 5;
    req = 4'b1001;
    tick();
    n_tests++; if (o_gnt !== 4'b0001) begin n_fail++; $display("FAIL drain_gnt0 got %b want 0001", o_gnt); end
    wait_resp(20, k);
    n_tests++; if (o_done !== 4'b0001) begin n_fail++; $display("FAIL drain_done got %b want 0001", o_done); end
    req = 4'b1000;
    wait_gnt(20, k);
    n_tests++; if (k != 7) begin n_fail++; $display("FAIL drain_wait got %0d want 7", k); end
    n_tests++; if (o_gnt !== 4'b1000) begin n_fail++; $display("FAIL drain_gnt3 got %b want 1000", o_gnt); end
    eng_hold = 0;
    wait_resp(20, k);
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_run();
    int k;
    do_reset();
    rand_patterns();
    eng_lat = 20; eng_hold = 0;
    req = 4'b0010;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    req = 4'b1010;
    tick();
    n_tests++; if (o_gnt !== '0 || o_done !== '0 || o_err !== '0) begin n_fail++;
      $display("FAIL mid_rst_pulses got %b/%b/%b want 0", o_gnt, o_done, o_err); end
    n_tests++; if (o_eng_valid !== 1'b0 || o_busy !== 1'b0 || o_eng_pattern !== '0) begin n_fail++;
      $display("FAIL mid_rst_eng got %b/%b/%h want 0", o_eng_valid, o_busy, o_eng_pattern); end
    reset = 1'b0;
    model_clear();
    tick();
    n_tests++; if (o_gnt !== onehot(rr_pick(req, m_rr))) begin n_fail++;
      $display("FAIL mid_rst_regrant got %b want %b", o_gnt, onehot(rr_pick(req, m_rr))); end
    wait_resp(40, k);
    m_tbl[1] = kmp(req_pat[PatW +: PatW], req_last[MPA +: MPA]);
    n_tests++; if (o_done !== 4'b0010 || o_ff_table !== m_pack()) begin n_fail++;
      $display("FAIL mid_rst_done got %b/%h want 0010/%h", o_done, o_ff_table, m_pack()); end
    req = '0;
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_watchdog();
    test_collision();
    test_drain_hold();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sme_ff_scheduler.md
SME_FF_SCHEDULER -- requirements
Module: sme_ff_scheduler

Interface
REQ-001 SHALL take parameters (name, default, meaning): NUM_REQ, 4, requester count; MAX_PATTERN, 8, pattern bytes; MAX_PAT_ADD, 3, index width; BYTE, 8, byte width; TIMEOUT, 64, engine watchdog cycles.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-003 SHALL have req in NUM_REQ per-slot computation request, level, held until done/err.
REQ-004 SHALL have req_pattern in NUM_REQ*MAX_PATTERN*BYTE per-slot pattern, byte 0 LSB.
REQ-005 SHALL have req_last_idx in NUM_REQ*MAX_PAT_ADD per-slot last valid pattern index.
REQ-006 SHALL have gnt out NUM_REQ, one-hot slot currently owning the engine.
REQ-007 SHALL have done out NUM_REQ, one-cycle result-captured pulse, and err out NUM_REQ, one-cycle watchdog pulse.
REQ-008 SHALL have ff_table out NUM_REQ*MAX_PATTERN*MAX_PAT_ADD per-slot failure-function table, and ff_valid out NUM_REQ per-slot table valid.
REQ-009 SHALL have busy out 1, engine occupied (state != IDLE).
REQ-010 SHALL have engine ports: eng_valid out 1, level request; eng_pattern out MAX_PATTERN*BYTE; eng_last_idx out MAX_PAT_ADD; eng_fail_func in MAX_PATTERN*MAX_PAT_ADD; eng_done in 1, level result-ready.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DRAIN; all outputs registered.
REQ-012 IDLE: when any req bit is 1, SHALL pick slot by round-robin starting at rr_ptr, and on the next edge enter RUN, set gnt one-hot, latch that slot's req_pattern/req_last_idx onto eng_pattern/eng_last_idx, assert eng_valid, clear that slot's ff_valid, clear watchdog counter.
REQ-013 rr_ptr SHALL update at grant to (granted slot + 1) mod NUM_REQ.
REQ-014 RUN: eng_valid and eng_pattern/eng_last_idx SHALL stay stable; watchdog SHALL increment each cycle.
REQ-015 RUN with eng_done=1: next edge SHALL write eng_fail_func into the granted slot's ff_table field, set its ff_valid, pulse its done bit, drop eng_valid and gnt, enter DRAIN.
REQ-016 RUN with watchdog == TIMEOUT-1 and eng_done=0: next edge SHALL pulse err for granted slot, leave ff_table/ff_valid unchanged (ff_valid stays 0), drop eng_valid and gnt, enter DRAIN.
REQ-017 eng_done and watchdog expiry in same cycle: done path SHALL win.
REQ-018 DRAIN: SHALL hold eng_valid=0 until eng_done=0 sampled, then enter IDLE; minimum one DRAIN cycle.
REQ-019 Requester dropping req during RUN SHALL NOT abort the job; result still captured and done pulsed.
REQ-020 Requester must drop req upon done/err; a req still high in IDLE SHALL be treated as a new request.
REQ-021 Grant-to-grant minimum spacing SHALL be 3 cycles (RUN, DRAIN, IDLE).
REQ-022 ff_table of non-granted slots SHALL never change.

Reset
REQ-023 On reset SHALL force IDLE; gnt, done, err, ff_valid, eng_valid, busy = 0; ff_table, eng_pattern, eng_last_idx = 0; rr_ptr = 0; watchdog = 0.
REQ-024 Reset mid-RUN SHALL abort without done/err pulse; engine sees eng_valid=0 the cycle after reset.

Structure
REQ-025 BYTE, MAX_PATTERN, MAX_PAT_ADD, NUM_REQ, TIMEOUT defaults and FSM state encodings SHALL live in the shared SME spec package/include.
REQ-026 Round-robin selection SHALL be a sub-module sme_rr_arbiter (req vector, rr_ptr in; one-hot grant, index out; combinational).

Verification
REQ-027 Single request: req[2]=1, pattern "ABABCABA", last_idx=7; engine model done after 10 cycles -> gnt=4'b0100 one cycle after req, done[2] pulse, ff_table slot2 = 0,0,1,2,0,1,2,3, ff_valid[2]=1.
REQ-028 Fairness: req=4'b1111 held, re-asserted after each done -> grant order 0,1,2,3,0; no slot granted twice before others served.
REQ-029 Watchdog: engine never asserts eng_done, req[1]=1 -> err[1] pulse exactly TIMEOUT cycles after grant, ff_valid[1]=0, DRAIN then IDLE.
REQ-030 Collision: eng_done rises on cycle TIMEOUT-1 -> done pulse, no err.
REQ-031 Drain hold: engine keeps eng_done high 5 cycles after eng_valid drop -> no new grant until eng_done low, even with req pending.
REQ-032 Reset mid-RUN: reset at cycle 4 of RUN -> all outputs 0 next cycle, no done/err, rr_ptr=0, next request granted normally.
